bsg_mul_iterative_arbiter: RTL and testbench
============================================

# bsg_mul_iterative_arbiter

Shares one iterative Booth multiplier (2*width_p result, multi-cycle, single operation in flight) among num_req_p requesters. Requests are accepted round-robin, operands are latched and issued, and the owner is tracked while the multiplier runs. Each product is returned to its originating requester through a per-requester valid/yumi response port. Sits between client pipelines (e.g. integer MUL units of several cores) and the multiplier's ready/valid/yumi interface.

## Interface
- num_req_p, 4: number of requesters, ≥2.
- width_p, 64: operand width; result is 2*width_p.
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_v_i  in  num_req_p  per-requester request valid.
- req_ready_o  out  num_req_p  one-hot accept; request i is consumed in a cycle where req_v_i[i] & req_ready_o[i].
- req_opA_i / req_opB_i  in  num_req_p×width_p  operands per requester.
- req_signed_i  in  num_req_p  signed multiply when 1.
- mul_v_o  out  1  issue valid to multiplier.
- mul_ready_i  in  1  multiplier idle/ready.
- mul_opA_o / mul_opB_o  out  width_p  latched operands.
- mul_signed_o  out  1  latched signed flag.
- mul_v_i  in  1  multiplier result valid.
- mul_result_i  in  2*width_p  product.
- mul_yumi_o  out  1  result consumed.
- resp_v_o  out  num_req_p  one-hot response valid (owner only).
- resp_result_o  out  2*width_p  registered product, shared by all requesters.
- resp_yumi_i  in  num_req_p  per-requester response consume.

## Operation
- FSM states: eIdle, eIssue, eBusy, eResp.
- eIdle: if any req_v_i, grant = first set bit at or after rr_ptr (wrapping); req_ready_o[grant]=1 combinationally (depends on req_v_i); latch operands, signed flag, owner=grant; rr_ptr ← grant+1 mod num_req_p; → eIssue. No request: stay, req_ready_o=0.
- eIssue: mul_v_o=1 with latched operands; on mul_ready_i → eBusy. Operands held stable until accepted.
- eBusy: wait for mul_v_i; on mul_v_i, mul_yumi_o=1 same cycle, resp_result_o register ← mul_result_i; → eResp.
- eResp: resp_v_o[owner]=1, result held stable; on resp_yumi_i[owner] → eIdle. resp_yumi_i of non-owners ignored.
- req_ready_o=0 in every state except eIdle; at most one bit ever set.
- mul_v_i outside eBusy is ignored (mul_yumi_o stays 0).
- Result is passed unmodified; no sign or width adjustment in this block.

## Timing
- Reset (async assert): state=eIdle, rr_ptr=0, owner=0, all outputs 0, result register 0. Release synchronous to clk_i; first grant favours requester 0.
- Reset mid-operation: in-flight op is dropped; multiplier is reset by the same reset_i, no response generated.
- Accept at cycle T → mul_v_o at T+1. Multiplier accepts at cycle A; result at cycle R; resp_v_o at R+1; earliest new accept one cycle after resp_yumi_i.
- Back-to-back: all requesters continuously valid → grants 0,1,2,…,num_req_p-1,0 (strict rotation).
- No bypass: resp_result_o is always registered.

## Configuration
- BSG_MUL_ARB_PERF_CNT_EN defined: extra output busy_cnt_o (32 bits), increments every cycle state≠eIdle, saturates at all-ones, cleared by reset; also per-requester grant counters grant_cnt_o (num_req_p×16, saturating).
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Package bsg_mul_arb_pkg: state enum (eIdle, eIssue, eBusy, eResp), perf-counter width constants.
- Sub-module bsg_mul_arb_rr_pick: combinational round-robin picker (req vector, rr_ptr → one-hot grant, grant index, any_v). Pointer register stays in the top.

## Test plan
- Reset then single request on requester 2 (opA=3, opB=5, unsigned) → req_ready_o=4'b0100 same cycle, mul_v_o next cycle, resp_v_o=4'b0100 with result 15 one cycle after mul_v_i.
- Signed: requester 0, opA=-1 (all ones), opB=2, signed=1 → mul_signed_o=1; with model multiplier, resp_result_o=128-bit -2.
- All four valid continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3; no requester granted twice in a row.
- Response stall: owner withholds resp_yumi_i 10 cycles → resp_v_o and resp_result_o stable; new req_v_i not accepted; other requesters' yumi ignored.
- mul_ready_i held 0 for 5 cycles in eIssue → mul_v_o stays 1, operands unchanged; spurious mul_v_i in eIssue → mul_yumi_o=0.
- reset_i asserted asynchronously in eBusy → all outputs 0 immediately without clock edge; after release, requester 0 granted first.

Source files
------------

// File: rtl/bsg_mul_arb_pkg.sv
// Shared types and constants for the iterative-multiplier arbiter.
package bsg_mul_arb_pkg;

   typedef enum logic [1:0] {
      eIdle  = 2'd0,
      eIssue = 2'd1,
      eBusy  = 2'd2,
      eResp  = 2'd3
   } state_e;

   localparam int unsigned BusyCntWidth  = 32;
   localparam int unsigned GrantCntWidth = 16;

endpackage

// File: rtl/bsg_mul_iterative_arbiter_if.sv
// Request, multiplier and response signals of the arbiter bundled together.
// Signal suffixes are from the arbiter's point of view; the arbiter uses the
// slave modport, and clients plus the multiplier drive the master modport.
interface bsg_mul_iterative_arbiter_if #(
   parameter int unsigned num_req_p = 4,
   parameter int unsigned width_p   = 64
);

   logic [num_req_p-1:0]              req_v_i;
   logic [num_req_p-1:0]              req_ready_o;
   logic [num_req_p-1:0][width_p-1:0] req_opA_i;
   logic [num_req_p-1:0][width_p-1:0] req_opB_i;
   logic [num_req_p-1:0]              req_signed_i;

   logic                              mul_v_o;
   logic                              mul_ready_i;
   logic [width_p-1:0]                mul_opA_o;
   logic [width_p-1:0]                mul_opB_o;
   logic                              mul_signed_o;
   logic                              mul_v_i;
   logic [2*width_p-1:0]              mul_result_i;
   logic                              mul_yumi_o;

   logic [num_req_p-1:0]              resp_v_o;
   logic [2*width_p-1:0]              resp_result_o;
   logic [num_req_p-1:0]              resp_yumi_i;

   modport slave (
      input  req_v_i, req_opA_i, req_opB_i, req_signed_i,
      input  mul_ready_i, mul_v_i, mul_result_i, resp_yumi_i,
      output req_ready_o, mul_v_o, mul_opA_o, mul_opB_o, mul_signed_o,
      output mul_yumi_o, resp_v_o, resp_result_o
   );

   modport master (
      output req_v_i, req_opA_i, req_opB_i, req_signed_i,
      output mul_ready_i, mul_v_i, mul_result_i, resp_yumi_i,
      input  req_ready_o, mul_v_o, mul_opA_o, mul_opB_o, mul_signed_o,
      input  mul_yumi_o, resp_v_o, resp_result_o
   );

endinterface

// File: rtl/bsg_mul_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping around, returned as one-hot and as an index.
module bsg_mul_arb_rr_pick #(
   parameter  int unsigned num_req_p = 4,
   localparam int unsigned PtrW      = $clog2(num_req_p)
) (
   input  logic [num_req_p-1:0] req_i,
   input  logic [PtrW-1:0]      ptr_i,
   output logic [num_req_p-1:0] grant_oh_o,
   output logic [PtrW-1:0]      grant_idx_o,
   output logic                 any_v_o
);

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      int unsigned idx;
      logic        found;
      idx         = 0;
      found       = 1'b0;
      grant_oh_o  = '0;
      grant_idx_o = '0;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         idx = (int'(ptr_i) + k) % num_req_p;
         if (!found && req_i[PtrW'(idx)]) begin
            found                   = 1'b1;
            grant_oh_o[PtrW'(idx)]  = 1'b1;
            grant_idx_o             = PtrW'(idx);
         end
      end
      any_v_o = found;
   end

endmodule

// File: rtl/bsg_mul_iterative_arbiter.sv
// Shares one iterative multiplier among num_req_p requesters: round-robin
// accept, latch-and-issue, wait for the product, return it to its owner.
// Optional BSG_MUL_ARB_PERF_CNT_EN adds saturating busy and grant counters.
module bsg_mul_iterative_arbiter
   import bsg_mul_arb_pkg::*;
#(
   parameter  int unsigned num_req_p = 4,
   parameter  int unsigned width_p   = 64,
   localparam int unsigned PtrW      = $clog2(num_req_p)
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   bsg_mul_iterative_arbiter_if.slave        bus_io
`ifdef BSG_MUL_ARB_PERF_CNT_EN
   ,
   output logic [BusyCntWidth-1:0]           busy_cnt_o,
   output logic [num_req_p*GrantCntWidth-1:0] grant_cnt_o
`endif
);

   state_e               state_q, state_d;
   logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PtrW-1:0]      owner_q, owner_d;
   logic [width_p-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic                 signed_q, signed_d;
   logic [2*width_p-1:0] result_q, result_d;

   logic [num_req_p-1:0] grant_oh;
   logic [PtrW-1:0]      grant_idx;
   logic                 any_v;
   logic                 accept;

   bsg_mul_arb_rr_pick #(
      .num_req_p (num_req_p)
   ) u_pick (
      .req_i       (bus_io.req_v_i),
      .ptr_i       (rr_ptr_q),
      .grant_oh_o  (grant_oh),
      .grant_idx_o (grant_idx),
      .any_v_o     (any_v)
   );

   // Next-state and handshake outputs; all outputs forced quiet during reset.
   always_comb begin
      state_d             = state_q;
      rr_ptr_d            = rr_ptr_q;
      owner_d             = owner_q;
      opa_d               = opa_q;
      opb_d               = opb_q;
      signed_d            = signed_q;
      result_d            = result_q;
      accept              = 1'b0;
      bus_io.req_ready_o  = '0;
      bus_io.mul_v_o      = 1'b0;
      bus_io.mul_yumi_o   = 1'b0;
      bus_io.resp_v_o     = '0;
      unique case (state_q)
         eIdle: begin
            if (any_v && !reset_i) begin
               accept             = 1'b1;
               bus_io.req_ready_o = grant_oh;
               opa_d              = bus_io.req_opA_i[grant_idx];
               opb_d              = bus_io.req_opB_i[grant_idx];
               signed_d           = bus_io.req_signed_i[grant_idx];
               owner_d            = grant_idx;
               rr_ptr_d           = (grant_idx == PtrW'(num_req_p - 1)) ? '0
                                                                         : grant_idx + PtrW'(1);
               state_d            = eIssue;
            end
         end
         eIssue: begin
            bus_io.mul_v_o = 1'b1;
            if (bus_io.mul_ready_i) state_d = eBusy;
         end
         eBusy: begin
            if (bus_io.mul_v_i) begin
               bus_io.mul_yumi_o = 1'b1;
               result_d          = bus_io.mul_result_i;
               state_d           = eResp;
            end
         end
         eResp: begin
            bus_io.resp_v_o[owner_q] = 1'b1;
            if (bus_io.resp_yumi_i[owner_q]) state_d = eIdle;
         end
         default: state_d = eIdle;
      endcase
   end

   // State, pointer, owner and datapath registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= eIdle;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         signed_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         signed_q <= signed_d;
         result_q <= result_d;
      end
   end

   assign bus_io.mul_opA_o     = opa_q;
   assign bus_io.mul_opB_o     = opb_q;
   assign bus_io.mul_signed_o  = signed_q;
   assign bus_io.resp_result_o = result_q;

`ifdef BSG_MUL_ARB_PERF_CNT_EN
   logic [BusyCntWidth-1:0]                   busy_cnt_q;
   logic [num_req_p-1:0][GrantCntWidth-1:0]   grant_cnt_q;

   // Saturating occupancy and per-requester grant counters.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         busy_cnt_q  <= '0;
         grant_cnt_q <= '0;
      end else begin
         if (state_q != eIdle && busy_cnt_q != '1) busy_cnt_q <= busy_cnt_q + 1'b1;
         for (int unsigned k = 0; k < num_req_p; k++) begin
            if (accept && grant_oh[k] && grant_cnt_q[k] != '1) begin
               grant_cnt_q[k] <= grant_cnt_q[k] + 1'b1;
            end
         end
      end
   end

   assign busy_cnt_o  = busy_cnt_q;
   assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_mul_iterative_arbiter.sv
// Self-checking bench for bsg_mul_iterative_arbiter with a behavioural
// round-robin and multiplication reference model.
module tb_bsg_mul_iterative_arbiter;

   localparam int NR = 4;
   localparam int W  = 64;

   logic clk;
   logic reset_i;
   int   checks = 0;
   int   errors = 0;

   bsg_mul_iterative_arbiter_if #(.num_req_p(NR), .width_p(W)) bus ();

`ifdef BSG_MUL_ARB_PERF_CNT_EN
   logic [31:0]      busy_cnt;
   logic [NR*16-1:0] grant_cnt;
`endif

   bsg_mul_iterative_arbiter #(
      .num_req_p (NR),
      .width_p   (W)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus_io  (bus.slave)
`ifdef BSG_MUL_ARB_PERF_CNT_EN
      ,
      .busy_cnt_o  (busy_cnt),
      .grant_cnt_o (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: round-robin pointer and per-requester operands.
   int         ptr_m;
   logic [W-1:0] opa [NR];
   logic [W-1:0] opb [NR];
   logic         sgn [NR];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [127:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
      logic signed [127:0] sa, sb;
      logic [127:0]        ua, ub;
      sa = {{64{a[W-1]}}, a};
      sb = {{64{b[W-1]}}, b};
      ua = {64'b0, a};
      ub = {64'b0, b};
      return s ? 128'(sa * sb) : ua * ub;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_i = 1'b1;
      bus.req_v_i = '0; bus.mul_ready_i = 1'b0; bus.mul_v_i = 1'b0; bus.resp_yumi_i = '0;
      tick();
      reset_i = 1'b0;
      ptr_m = 0;
   endtask

   // One full transaction: accept, issue (with optional stall), busy, response.
   task automatic do_txn(input logic [NR-1:0] vmask, input int rdy_dly, input int lat,
                         input int stall, input bit spur, output int g);
      logic [NR-1:0] oh;
      logic [127:0]  prod;
      g = -1;
      for (int k = 0; k < NR; k++) begin
         bus.req_opA_i[k]    = opa[k];
         bus.req_opB_i[k]    = opb[k];
         bus.req_signed_i[k] = sgn[k];
      end
      bus.req_v_i = vmask;
      #1;
      for (int k = 0; k < NR; k++) begin
         if (g < 0 && vmask[(ptr_m + k) % NR]) g = (ptr_m + k) % NR;
      end
      oh   = NR'(1) << g;
      prod = ref_mul(opa[g], opb[g], sgn[g]);
      chk("req_ready_grant", bus.req_ready_o, oh);
      tick();
      // Disturb the granted inputs: the latched copies must not follow.
      bus.req_opA_i[g]    = ~opa[g];
      bus.req_opB_i[g]    = ~opb[g];
      bus.req_signed_i[g] = ~sgn[g];
      #1;
      chk("issue_mul_v", bus.mul_v_o, 1'b1);
      chk("issue_opA", bus.mul_opA_o, opa[g]);
      chk("issue_opB", bus.mul_opB_o, opb[g]);
      chk("issue_signed", bus.mul_signed_o, sgn[g]);
      chk("issue_no_ready", bus.req_ready_o, 0);
      for (int i = 0; i < rdy_dly; i++) begin
         bus.mul_v_i = spur;
         bus.mul_result_i = rnd128();
         #1;
         chk("issue_spurious_yumi", bus.mul_yumi_o, 1'b0);
         tick();
         chk("issue_hold_v", bus.mul_v_o, 1'b1);
         chk("issue_hold_opA", bus.mul_opA_o, opa[g]);
         chk("issue_hold_opB", bus.mul_opB_o, opb[g]);
      end
      bus.mul_v_i = 1'b0;
      bus.mul_ready_i = 1'b1;
      tick();
      bus.mul_ready_i = 1'b0;
      chk("busy_mul_v_low", bus.mul_v_o, 1'b0);
      for (int i = 0; i < lat; i++) begin
         chk("busy_no_resp", bus.resp_v_o, 0);
         tick();
      end
      bus.mul_v_i = 1'b1;
      bus.mul_result_i = prod;
      #1;
      chk("busy_yumi", bus.mul_yumi_o, 1'b1);
      tick();
      bus.mul_v_i = 1'b0;
      bus.mul_result_i = rnd128();
      #1;
      chk("resp_v", bus.resp_v_o, oh);
      chk("resp_result", bus.resp_result_o, prod);
      chk("resp_no_yumi", bus.mul_yumi_o, 1'b0);
      for (int i = 0; i < stall; i++) begin
         bus.resp_yumi_i = NR'($urandom) & ~oh;
         bus.req_v_i = vmask | NR'($urandom);
         #1;
         chk("stall_resp_v", bus.resp_v_o, oh);
         chk("stall_result", bus.resp_result_o, prod);
         chk("stall_no_ready", bus.req_ready_o, 0);
         tick();
      end
      bus.req_v_i = vmask;
      bus.resp_yumi_i = oh;
      tick();
      bus.resp_yumi_i = '0;
      #1;
      chk("resp_done", bus.resp_v_o, 0);
      ptr_m = (g + 1) % NR;
   endtask

   initial begin
      int g, prev;
      reset_i = 1'b1;
      bus.req_v_i = '0; bus.req_opA_i = '0; bus.req_opB_i = '0; bus.req_signed_i = '0;
      bus.mul_ready_i = 1'b0; bus.mul_v_i = 1'b0; bus.mul_result_i = '0; bus.resp_yumi_i = '0;
      for (int k = 0; k < NR; k++) begin opa[k] = '0; opb[k] = '0; sgn[k] = 1'b0; end
      ptr_m = 0;
      #12;
      chk("rst_req_ready", bus.req_ready_o, 0);
      chk("rst_mul_v", bus.mul_v_o, 1'b0);
      chk("rst_resp_v", bus.resp_v_o, 0);
      chk("rst_mul_yumi", bus.mul_yumi_o, 1'b0);
      chk("rst_result", bus.resp_result_o, 0);
      chk("rst_opA", bus.mul_opA_o, 0);
      @(negedge clk);
      reset_i = 1'b0;

      // Single unsigned request on requester 2.
      opa[2] = 64'd3; opb[2] = 64'd5; sgn[2] = 1'b0;
      do_txn(4'b0100, 0, 2, 0, 1'b0, g);
      chk("unsigned_15", bus.resp_result_o, 128'd15);
      bus.req_v_i = '0;
      tick();

      // Signed -1 * 2 on requester 0.
      opa[0] = '1; opb[0] = 64'd2; sgn[0] = 1'b1;
      do_txn(4'b0001, 0, 1, 0, 1'b0, g);
      chk("signed_minus2", bus.resp_result_o, {{127{1'b1}}, 1'b0});
      bus.req_v_i = '0;

      // All requesters continuously valid: strict rotation from 0.
      do_reset();
      prev = -1;
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < NR; k++) begin
            opa[k] = {$urandom, $urandom}; opb[k] = {$urandom, $urandom};
            sgn[k] = 1'($urandom);
         end
         do_txn(4'b1111, $urandom_range(0, 1), $urandom_range(0, 3), 0, 1'b0, g);
         chk("rotation_order", 32'(g), 32'(t % NR));
         chk("no_repeat_grant", 32'(g == prev), 32'd0);
         prev = g;
      end
      bus.req_v_i = '0;
      tick();

      // Response stall of 10 cycles with other requesters poking yumi.
      for (int k = 0; k < NR; k++) begin
         opa[k] = {$urandom, $urandom}; opb[k] = {$urandom, $urandom}; sgn[k] = 1'($urandom);
      end
      do_txn(4'b0110, 0, 2, 10, 1'b0, g);
      bus.req_v_i = '0;
      tick();

      // Multiplier not ready for 5 cycles, with spurious results offered.
      opa[3] = {$urandom, $urandom}; opb[3] = {$urandom, $urandom}; sgn[3] = 1'b1;
      do_txn(4'b1000, 5, 1, 0, 1'b1, g);
      bus.req_v_i = '0;
      tick();

      // Random mix of request patterns, latencies and stalls.
      for (int t = 0; t < 10; t++) begin
         for (int k = 0; k < NR; k++) begin
            opa[k] = {$urandom, $urandom}; opb[k] = {$urandom, $urandom};
            sgn[k] = 1'($urandom);
         end
         do_txn(NR'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4),
                $urandom_range(0, 3), 1'($urandom), g);
         if ($urandom_range(0, 1) == 1) begin
            bus.req_v_i = '0;
            tick();
         end
      end

      // Asynchronous reset while the multiplier is busy.
      bus.req_v_i = '0;
      tick();
      opa[3] = 64'd7; opb[3] = 64'd9; sgn[3] = 1'b0;
      bus.req_opA_i[3] = opa[3]; bus.req_opB_i[3] = opb[3]; bus.req_signed_i[3] = 1'b0;
      bus.req_v_i = 4'b1000;
      tick();
      bus.mul_ready_i = 1'b1;
      tick();
      bus.mul_ready_i = 1'b0;
      bus.mul_v_i = 1'b1;
      bus.mul_result_i = 128'd63;
      #2;
      reset_i = 1'b1;
      #1;
      chk("arst_req_ready", bus.req_ready_o, 0);
      chk("arst_mul_v", bus.mul_v_o, 1'b0);
      chk("arst_mul_yumi", bus.mul_yumi_o, 1'b0);
      chk("arst_resp_v", bus.resp_v_o, 0);
      chk("arst_opA", bus.mul_opA_o, 0);
      chk("arst_result", bus.resp_result_o, 0);
      bus.mul_v_i = 1'b0;
      bus.req_v_i = '0;
      tick();
      reset_i = 1'b0;
      ptr_m = 0;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_no_resp", bus.resp_v_o, 0);
         tick();
      end
      opa[0] = {$urandom, $urandom}; opb[0] = {$urandom, $urandom}; sgn[0] = 1'b0;
      do_txn(4'b1001, 0, 1, 0, 1'b0, g);
      chk("post_rst_first_grant", 32'(g), 32'd0);
      bus.req_v_i = '0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
